// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router write-side controller.
package router_pkg;

    typedef logic [1:0] port_addr_t;

    localparam port_addr_t PORT0     = 2'd0;
    localparam port_addr_t PORT1     = 2'd1;
    localparam port_addr_t PORT2     = 2'd2;
    localparam port_addr_t PORT_NONE = 2'd3;

    localparam int TIMEOUT_CYCLES = 30;

endpackage

// File: rtl/router_stall_timer.sv
// Per-port reader-stall watchdog: one-cycle soft_reset after TIMEOUT stalled cycles.
module router_stall_timer #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic resetn,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;
    logic             stall;

    assign stall = vld & ~rd;

    // Clearing on terminal count keeps the pulse one cycle wide and restarts the window.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt        <= '0;
            soft_reset <= 1'b0;
        end else if (stall && cnt == CNT_LAST) begin
            cnt        <= '0;
            soft_reset <= 1'b1;
        end else if (stall) begin
            cnt        <= cnt + CNT_W'(1);
            soft_reset <= 1'b0;
        end else begin
            cnt        <= '0;
            soft_reset <= 1'b0;
        end
    end

endmodule

// File: rtl/router_sync_ctrl.sv
// Router write steering: latched destination, one-hot FIFO write enables,
// addressed full flag, valid-out and per-port stall watchdogs.
module router_sync_ctrl
    import router_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_CYCLES,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       detect_add,
    input  logic [1:0] data_in,
    input  logic       write_enb_reg,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       full_0,
    input  logic       full_1,
    input  logic       full_2,
    output logic [2:0] write_enb,
    output logic       fifo_full,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2
);

    port_addr_t addr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr <= PORT0;
        end else if (detect_add) begin
            addr <= port_addr_t'(data_in);
        end
    end

    // PORT_NONE drops the packet: no write enable and never report full.
    always_comb begin
        write_enb = 3'b000;
        fifo_full = 1'b0;
        case (addr)
            PORT0: begin
                write_enb = {2'b00, write_enb_reg};
                fifo_full = full_0;
            end
            PORT1: begin
                write_enb = {1'b0, write_enb_reg, 1'b0};
                fifo_full = full_1;
            end
            PORT2: begin
                write_enb = {write_enb_reg, 2'b00};
                fifo_full = full_2;
            end
            default: begin
                write_enb = 3'b000;
                fifo_full = 1'b0;
            end
        endcase
    end

    assign vld_out_0 = ~empty_0;
    assign vld_out_1 = ~empty_1;
    assign vld_out_2 = ~empty_2;

    router_stall_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer_0 (
        .clk        (clk),
        .resetn     (resetn),
        .vld        (vld_out_0),
        .rd         (read_enb_0),
        .soft_reset (soft_reset_0)
    );

    router_stall_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer_1 (
        .clk        (clk),
        .resetn     (resetn),
        .vld        (vld_out_1),
        .rd         (read_enb_1),
        .soft_reset (soft_reset_1)
    );

    router_stall_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer_2 (
        .clk        (clk),
        .resetn     (resetn),
        .vld        (vld_out_2),
        .rd         (read_enb_2),
        .soft_reset (soft_reset_2)
    );

endmodule

// File: tb/tb_router_sync_ctrl.sv
// Directed bench for router_sync_ctrl with hand-computed expectations.
module tb_router_sync_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       detect_add;
    logic [1:0] data_in;
    logic       write_enb_reg;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic       empty_0, empty_1, empty_2;
    logic       full_0, full_1, full_2;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    router_sync_ctrl dut (
        .clk           (clk),
        .resetn        (resetn),
        .detect_add    (detect_add),
        .data_in       (data_in),
        .write_enb_reg (write_enb_reg),
        .read_enb_0    (read_enb_0),
        .read_enb_1    (read_enb_1),
        .read_enb_2    (read_enb_2),
        .empty_0       (empty_0),
        .empty_1       (empty_1),
        .empty_2       (empty_2),
        .full_0        (full_0),
        .full_1        (full_1),
        .full_2        (full_2),
        .write_enb     (write_enb),
        .fifo_full     (fifo_full),
        .vld_out_0     (vld_out_0),
        .vld_out_1     (vld_out_1),
        .vld_out_2     (vld_out_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] sr();
        return {soft_reset_2, soft_reset_1, soft_reset_0};
    endfunction

    initial begin
        resetn = 1'b0; detect_add = 1'b0; data_in = 2'd0; write_enb_reg = 1'b0;
        read_enb_0 = 1'b0; read_enb_1 = 1'b0; read_enb_2 = 1'b0;
        empty_0 = 1'b0; empty_1 = 1'b0; empty_2 = 1'b0;
        full_0 = 1'b0; full_1 = 1'b0; full_2 = 1'b0;

        // Reset with all ports stalled
        tick();
        chk("rst_sr_c1", 32'(sr()), 32'd0);
        tick();
        chk("rst_sr_c2", 32'(sr()), 32'd0);
        chk("rst_vld", 32'({vld_out_2, vld_out_1, vld_out_0}), 32'b111);
        resetn = 1'b1;
        empty_0 = 1'b1; empty_1 = 1'b1; empty_2 = 1'b1;
        data_in = 2'd2; write_enb_reg = 1'b1;
        #1;
        chk("rst_addr0_we", 32'(write_enb), 32'b001);
        chk("rst_vld_off", 32'({vld_out_2, vld_out_1, vld_out_0}), 32'b000);
        tick();
        chk("hold_addr0_we", 32'(write_enb), 32'b001);

        // Steer to port 1
        write_enb_reg = 1'b0; detect_add = 1'b1; data_in = 2'd1;
        tick();
        detect_add = 1'b0; data_in = 2'd2; write_enb_reg = 1'b1;
        #1;
        chk("p1_we", 32'(write_enb), 32'b010);
        full_1 = 1'b1;
        #1;
        chk("p1_full", 32'(fifo_full), 32'd1);
        full_0 = 1'b1; full_1 = 1'b0;
        #1;
        chk("p1_full_other", 32'(fifo_full), 32'd0);
        write_enb_reg = 1'b0;
        #1;
        chk("p1_we_idle", 32'(write_enb), 32'b000);

        // Steer to port 2
        detect_add = 1'b1; data_in = 2'd2;
        tick();
        detect_add = 1'b0; write_enb_reg = 1'b1; full_0 = 1'b0; full_2 = 1'b1;
        #1;
        chk("p2_we", 32'(write_enb), 32'b100);
        chk("p2_full", 32'(fifo_full), 32'd1);

        // Invalid port
        detect_add = 1'b1; data_in = 2'd3; write_enb_reg = 1'b0;
        tick();
        detect_add = 1'b0; write_enb_reg = 1'b1;
        full_0 = 1'b1; full_1 = 1'b1; full_2 = 1'b1;
        #1;
        chk("none_we", 32'(write_enb), 32'b000);
        chk("none_full", 32'(fifo_full), 32'd0);
        write_enb_reg = 1'b0; full_0 = 1'b0; full_1 = 1'b0; full_2 = 1'b0;

        // Port 0 timeout: pulses after edges 30 and 60
        empty_0 = 1'b0; read_enb_0 = 1'b0;
        #1;
        chk("to_vld0", 32'(vld_out_0), 32'd1);
        for (int k = 1; k <= 61; k++) begin
            tick();
            chk($sformatf("to_sr0_e%0d", k), 32'(sr()),
                (k == 30 || k == 60) ? 32'b001 : 32'b000);
        end
        empty_0 = 1'b1;
        tick();

        // Port 1 rescued by a read in cycle 29
        empty_1 = 1'b0; read_enb_1 = 1'b0;
        for (int k = 1; k <= 61; k++) begin
            tick();
            chk($sformatf("rs_sr_e%0d", k), 32'(sr()), (k == 60) ? 32'b010 : 32'b000);
            read_enb_1 = (k == 29);
        end
        empty_1 = 1'b1; read_enb_1 = 1'b0;
        tick();

        // Reset on the edge a pulse is due suppresses it
        empty_2 = 1'b0;
        for (int k = 1; k <= 29; k++) tick();
        resetn = 1'b0;
        tick();
        chk("sup_sr_e30", 32'(sr()), 32'd0);
        resetn = 1'b1;
        tick();
        chk("sup_sr_e31", 32'(sr()), 32'd0);
        empty_2 = 1'b1;
        tick();

        // All ports stalled, reset at edge 15; pulse together 30 edges later
        empty_0 = 1'b0; empty_1 = 1'b0; empty_2 = 1'b0;
        for (int k = 1; k <= 46; k++) begin
            if (k == 15) resetn = 1'b0;
            tick();
            resetn = 1'b1;
            chk($sformatf("cc_sr_e%0d", k), 32'(sr()), (k == 45) ? 32'b111 : 32'b000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/router_sync_ctrl.md
Name: router_sync_ctrl

Overview:
Write-side steering and output-watchdog controller for the 1x3 router. It latches the destination address captured during the router FSM's address-decode phase. It converts the FSM's single write strobe into a one-hot write enable for the three output FIFOs and muxes the selected FIFO's full flag back to the FSM. It also drives per-port valid-out and times each port with a watchdog that soft-resets any FIFO whose reader stalls too long.

Parameters:
TIMEOUT, 30, consecutive stalled cycles (vld_out=1, read_enb=0) before the port's soft_reset fires; legal range 2..255.
CNT_W, 5, stall counter width; must satisfy 2**CNT_W >= TIMEOUT.

Ports:
clk  input  1  system clock, all state updates on rising edge
resetn  input  1  synchronous active-low reset
detect_add  input  1  FSM in address-decode state; load address this cycle
data_in  input  2  header address field (0,1,2 valid; 3 = no port)
write_enb_reg  input  1  FSM write strobe for the current byte
read_enb_0/1/2  input  1 each  downstream reader pops FIFO 0/1/2
empty_0/1/2  input  1 each  FIFO 0/1/2 empty flag
full_0/1/2  input  1 each  FIFO 0/1/2 full flag
write_enb  output  3  one-hot FIFO write enable, bit n = FIFO n
fifo_full  output  1  full flag of the addressed FIFO
vld_out_0/1/2  output  1 each  FIFO n holds data
soft_reset_0/1/2  output  1 each  one-cycle clear pulse to FIFO n and the FSM

Behaviour:
- Reset (resetn=0 at rising edge):
  - addr register <= 2'b00; all stall counters <= 0; soft_reset_0/1/2 <= 0.
  - Combinational outputs follow their inputs, with addr = 0.
- Address register:
  - When detect_add=1, addr <= data_in on the rising edge; otherwise it holds.
  - A load is not blocked by a simultaneous soft_reset.
- write_enb is combinational, zero latency:
  - addr=0 -> {2'b00, write_enb_reg}; addr=1 -> {1'b0, write_enb_reg, 1'b0}; addr=2 -> {write_enb_reg, 2'b00}.
  - addr=3 -> 3'b000. A packet to an invalid port is never written.
- fifo_full is combinational: full_0, full_1 or full_2 selected by addr; forced to 0 when addr=3.
- vld_out_n = ~empty_n, combinational.
- Stall watchdog, independent per port n, registered:
  - stall_n = vld_out_n & ~read_enb_n.
  - If stall_n and cnt_n == TIMEOUT-1: soft_reset_n <= 1, cnt_n <= 0.
  - Else if stall_n: cnt_n <= cnt_n+1, soft_reset_n <= 0.
  - Else: cnt_n <= 0, soft_reset_n <= 0.
  - soft_reset_n therefore rises on the edge that closes the TIMEOUT-th consecutive stalled cycle and is high for exactly one cycle.
  - Any single cycle with read_enb_n=1 or empty_n=1 restarts the count from 0.
  - If the FIFO is still non-empty and unread after the pulse, counting restarts. The next pulse comes TIMEOUT cycles later; no back-to-back pulses.
- The three ports may pulse in the same cycle; each is fully independent.
- Reset mid-count clears the counter. A pulse due on that edge is suppressed.
- Counters saturate at neither end: the range 0..TIMEOUT-1 is enforced by the clear.

Decomposition:
- Shared package router_pkg:
  - port address constants PORT0=2'd0, PORT1=2'd1, PORT2=2'd2, PORT_NONE=2'd3;
  - default TIMEOUT_CYCLES=30;
  - typedef port_addr_t (2-bit).
- One natural sub-module, router_stall_timer:
  - ports: clk, resetn, vld, rd, soft_reset; parameters TIMEOUT, CNT_W;
  - instantiated three times.
- Address register and decode stay in the top level.

Test Plan:
- Reset: resetn=0 for 2 cycles with empty_n=0 and read_enb_n=0 -> soft_reset_n=0 and counters 0 throughout; after release, data_in=2 and write_enb_reg=1 with detect_add=0 -> write_enb=3'b001 (addr still 0).
- Address steer: detect_add=1 with data_in=1 for one cycle, then write_enb_reg=1 -> write_enb=3'b010; full_1=1 -> fifo_full=1; full_0=1, full_1=0 -> fifo_full=0.
- Invalid port: detect_add=1 with data_in=3, then write_enb_reg=1 and full_0..2=3'b111 -> write_enb=3'b000, fifo_full=0.
- Timeout: empty_0=0 and read_enb_0=0 held from cycle 0 -> soft_reset_0=1 only after edge 30 (cycle 30), 0 in cycles 1..29 and 31; second pulse after edge 60.
- Rescue read: empty_1=0 with read_enb_1=0 for 29 cycles, read_enb_1=1 at cycle 29, then stall again -> no pulse at cycle 30; first pulse 30 cycles after the read.
- Concurrent: all three ports stalled from the same cycle, with resetn=0 at cycle 15 -> no pulse at cycle 30; all three soft_reset pulse together 30 cycles after reset release.
